// File: rtl/lfsr_rand_sched_pkg.sv
// Shared types and constants for the LFSR random-word sequencer.
// Imported by the interface, arbiter and sequencer top.
package lfsr_rand_sched_pkg;

  localparam int LFSR_W = 4;

  localparam logic [LFSR_W-1:0] ZERO_SEED_FIX = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] fix_seed(
    input logic [LFSR_W-1:0] s
  );
    return (s == '0) ? ZERO_SEED_FIX : s;
  endfunction

endpackage

// File: rtl/lfsr_rand_sched_if.sv
// Requester, seed and LFSR-side signals of the sequencer.
// slave = sequencer side, master = environment side.
interface lfsr_rand_sched_if
  import lfsr_rand_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int OUT_W = 8
);

  logic [NREQ-1:0]   req;
  logic              seed_wr;
  logic [LFSR_W-1:0] seed;
  logic [NREQ-1:0]   rnd_valid;
  logic [OUT_W-1:0]  rnd_data;
  logic              busy;
  logic              lfsr_in;
  logic [LFSR_W-1:0] lfsr_ctrl;
  logic              lfsr_q;

  modport slave (
    input  req,
    input  seed_wr,
    input  seed,
    input  lfsr_q,
    output rnd_valid,
    output rnd_data,
    output busy,
    output lfsr_in,
    output lfsr_ctrl
  );

  modport master (
    output req,
    output seed_wr,
    output seed,
    output lfsr_q,
    input  rnd_valid,
    input  rnd_data,
    input  busy,
    input  lfsr_in,
    input  lfsr_ctrl
  );

endinterface

// File: rtl/lfsr_rand_sched_rr_arbiter.sv
// Combinational round-robin pick: first request at or
// after ptr_i, wrapping.
module lfsr_rand_sched_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic            gnt_vld_o,
  output logic [PW-1:0]   gnt_idx_o
);

  int idx;

  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_sched.sv
// Round-robin sequencer sharing one external 4-bit LFSR:
// seeds it when needed, shifts OUT_W bits, acks the word.
module lfsr_rand_sched
  import lfsr_rand_sched_pkg::*;
#(
  parameter int                NREQ         = 2,
  parameter int                OUT_W        = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 4'b1001
) (
  input logic               clk_i,
  input logic               reset_i,
  lfsr_rand_sched_if.slave  bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);
  localparam logic [PW-1:0] GNT_LAST = PW'(NREQ - 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OUT_W-1:0]  sh_q, sh_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic [LFSR_W-1:0] seed_q, seed_d;
  logic              need_q, need_d;

  logic              arb_vld;
  logic [PW-1:0]     arb_idx;
  logic [OUT_W-1:0]  sh_nxt;
  logic [NREQ-1:0]   vld;

  lfsr_rand_sched_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .gnt_vld_o (arb_vld),
    .gnt_idx_o (arb_idx)
  );

  assign sh_nxt = {sh_q[OUT_W-2:0], bus.lfsr_q};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      seed_q  <= DEFAULT_SEED;
      need_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      seed_q  <= seed_d;
      need_q  <= need_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    seed_d  = seed_q;
    need_d  = need_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          gnt_d   = arb_idx;
          cnt_d   = '0;
          state_d = need_q ? ST_LOAD : ST_SHIFT;
        end
      end
      ST_LOAD: begin
        need_d  = 1'b0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sh_d  = sh_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          data_d  = sh_nxt;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = (gnt_q == GNT_LAST) ? '0 : gnt_q + PW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A seed write overrides the LOAD clear so the new seed still gets used.
    if (bus.seed_wr) begin
      seed_d = fix_seed(bus.seed);
      need_d = 1'b1;
    end
  end

  always_comb begin
    vld = '0;
    if (state_q == ST_DONE) begin
      vld[gnt_q] = 1'b1;
    end
  end

  assign bus.rnd_valid = vld;
  assign bus.rnd_data  = data_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.lfsr_in   = (state_q == ST_LOAD);
  assign bus.lfsr_ctrl = seed_q;

endmodule

// File: tb/tb_lfsr_rand_sched.sv
// Directed bench for lfsr_rand_sched with a clock-enabled
// 4-bit LFSR beside it (Q = o[2]^o[3]).
module tb_lfsr_rand_sched;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lfsr_rand_sched_if #(.NREQ(2), .OUT_W(8)) bus ();

  lfsr_rand_sched #(
    .NREQ         (2),
    .OUT_W        (8),
    .DEFAULT_SEED (4'b1001)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  logic [3:0] lst;

  always_ff @(posedge clk) begin
    if (reset)
      lst <= 4'b0000;
    else if (bus.lfsr_in)
      lst <= bus.lfsr_ctrl;
    else if (bus.busy && bus.rnd_valid == 2'b00)
      lst <= {lst[2:0], lst[2] ^ lst[3]};
  end

  assign bus.lfsr_q = lst[2] ^ lst[3];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.req     = 2'b00;
    bus.seed_wr = 1'b0;
    bus.seed    = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Runs one transaction; optional seed write at edge count seed_at.
  task automatic txn(input  logic [1:0] r,
                     input  int         seed_at,
                     input  logic [3:0] sv,
                     output int         n,
                     output logic [1:0] v,
                     output logic [7:0] d);
    n = 0;
    v = 2'b00;
    d = 8'h00;
    bus.req = r;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      bus.seed_wr = (n == seed_at);
      bus.seed    = sv;
      if (bus.rnd_valid != 2'b00) begin
        v = bus.rnd_valid;
        d = bus.rnd_data;
        break;
      end
    end
    bus.seed_wr = 1'b0;
    bus.req     = 2'b00;
    @(posedge clk);
    #1;
  endtask

  int         n;
  logic [1:0] v;
  logic [7:0] d;
  logic [1:0] av [3];
  logic [7:0] ad [3];
  int         at [3];
  int         k;
  int         bad;

  initial begin
    do_reset();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_vld", 32'(bus.rnd_valid), 32'd0);
    chk("rst_data", 32'(bus.rnd_data), 32'd0);
    chk("rst_lin", 32'(bus.lfsr_in), 32'd0);
    chk("rst_ctrl", 32'(bus.lfsr_ctrl), 32'h9);

    txn(2'b01, 0, 4'h0, n, v, d);
    chk("t1_lat", n, 10);
    chk("t1_vld", 32'(v), 32'h1);
    chk("t1_data", 32'(d), 32'hAF);
    chk("t1_hold", 32'(bus.rnd_data), 32'hAF);
    chk("t1_idle", 32'(bus.busy), 32'd0);

    txn(2'b01, 0, 4'h0, n, v, d);
    chk("t2_lat", n, 9);
    chk("t2_vld", 32'(v), 32'h1);
    chk("t2_data", 32'(d), 32'h13);

    do_reset();
    bus.req = 2'b11;
    k   = 0;
    bad = 0;
    for (int c = 1; c <= 60 && k < 3; c++) begin
      @(posedge clk);
      #1;
      if (bus.rnd_valid == 2'b11) bad++;
      if (bus.rnd_valid != 2'b00) begin
        av[k] = bus.rnd_valid;
        ad[k] = bus.rnd_data;
        at[k] = c;
        k++;
      end
    end
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    chk("t3_cnt", k, 3);
    chk("t3_multi", bad, 0);
    chk("t3_v0", 32'(av[0]), 32'h1);
    chk("t3_d0", 32'(ad[0]), 32'hAF);
    chk("t3_v1", 32'(av[1]), 32'h2);
    chk("t3_d1", 32'(ad[1]), 32'h13);
    chk("t3_gap", at[1] - at[0], 10);
    chk("t3_v2", 32'(av[2]), 32'h1);
    chk("t3_d2", 32'(ad[2]), 32'h5E);

    bus.seed_wr = 1'b1;
    bus.seed    = 4'h0;
    @(posedge clk);
    #1;
    bus.seed_wr = 1'b0;
    chk("t4_ctrl", 32'(bus.lfsr_ctrl), 32'h1);
    txn(2'b10, 0, 4'h0, n, v, d);
    chk("t4_lat", n, 10);
    chk("t4_vld", 32'(v), 32'h2);
    chk("t4_data", 32'(d), 32'h35);

    do_reset();
    bus.req = 2'b01;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_busy_pre", 32'(bus.busy), 32'd1);
    bus.req = 2'b00;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_vld", 32'(bus.rnd_valid), 32'd0);
    chk("t5_ctrl", 32'(bus.lfsr_ctrl), 32'h9);
    txn(2'b01, 0, 4'h0, n, v, d);
    chk("t5_lat", n, 10);
    chk("t5_data", 32'(d), 32'hAF);

    do_reset();
    txn(2'b01, 5, 4'h1, n, v, d);
    chk("t6_lat", n, 10);
    chk("t6_data", 32'(d), 32'hAF);
    chk("t6_ctrl", 32'(bus.lfsr_ctrl), 32'h1);
    txn(2'b01, 0, 4'h0, n, v, d);
    chk("t6b_lat", n, 10);
    chk("t6b_data", 32'(d), 32'h35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
